apb_mem_slave: RTL

APB3 slave front-end for the 256×8 synchronous scratch memory. It converts APB setup/access phases into single-cycle memory strobes (chip-enable, write-enable, read-enable, address, write data), registered for timing. It returns read data through PRDATA with a fixed wait-state count, and flags out-of-range addresses with PSLVERR without touching the memory. The block sits between the APB interconnect and the memory.

---
 rtl/apb_mem_slave_if.sv | 25 ++
 rtl/apb_mem_slave.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/apb_mem_slave_if.sv
// APB3 bus bundle between the interconnect and the scratch-memory front-end.
// Signal names follow the APB3 convention so they read the same as the bus documentation.
interface apb_mem_slave_if #(
   parameter int PADDR_WIDTH = 32,
   parameter int DATA_WIDTH  = 8
);
   logic                   PSEL;
   logic                   PENABLE;
   logic                   PWRITE;
   logic [PADDR_WIDTH-1:0] PADDR;
   logic [DATA_WIDTH-1:0]  PWDATA;
   logic [DATA_WIDTH-1:0]  PRDATA;
   logic                   PREADY;
   logic                   PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb_mem_slave.sv
// APB3 slave front-end for a synchronous scratch memory: one registered memory strobe per
// transfer, fixed wait states, PSLVERR for addresses above the memory range.
//
// state | meaning
// IDLE  | waiting for a setup phase; in-range -> strobe memory, out-of-range -> error response
// CMD   | memory strobes high this cycle; memory acts on the closing edge
// WAIT  | read data from memory is valid; capture it into PRDATA
// RESP  | PREADY high for one cycle, transfer completes
module apb_mem_slave #(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 8,
   parameter int PADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   apb_mem_slave_if.slave        apb,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_ce,
   output logic                  mem_wren,
   output logic                  mem_rden,
   output logic [DATA_WIDTH-1:0] mem_wr_data,
   input  logic [DATA_WIDTH-1:0] mem_rd_data
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   state_t                r_state;
   logic                  r_is_wr;
   logic [DATA_WIDTH-1:0] r_prdata;
   logic                  r_pready;
   logic                  r_pslverr;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic                  r_mem_ce;
   logic                  r_mem_wren;
   logic                  r_mem_rden;
   logic [DATA_WIDTH-1:0] r_mem_wr_data;

   state_t                w_state_nxt;
   logic                  w_is_wr_nxt;
   logic [DATA_WIDTH-1:0] w_prdata_nxt;
   logic                  w_pready_nxt;
   logic                  w_pslverr_nxt;
   logic [ADDR_WIDTH-1:0] w_mem_addr_nxt;
   logic                  w_mem_ce_nxt;
   logic                  w_mem_wren_nxt;
   logic                  w_mem_rden_nxt;
   logic [DATA_WIDTH-1:0] w_mem_wr_data_nxt;

   logic                  w_setup;
   logic                  w_in_range;

   // Only the setup cycle is acted on; PENABLE=1 seen in IDLE is a master error and ignored.
   assign w_setup    = apb.PSEL && !apb.PENABLE;
   assign w_in_range = (apb.PADDR[PADDR_WIDTH-1:ADDR_WIDTH] == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_is_wr       <= 1'b0;
         r_prdata      <= '0;
         r_pready      <= 1'b0;
         r_pslverr     <= 1'b0;
         r_mem_addr    <= '0;
         r_mem_ce      <= 1'b0;
         r_mem_wren    <= 1'b0;
         r_mem_rden    <= 1'b0;
         r_mem_wr_data <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_is_wr       <= w_is_wr_nxt;
         r_prdata      <= w_prdata_nxt;
         r_pready      <= w_pready_nxt;
         r_pslverr     <= w_pslverr_nxt;
         r_mem_addr    <= w_mem_addr_nxt;
         r_mem_ce      <= w_mem_ce_nxt;
         r_mem_wren    <= w_mem_wren_nxt;
         r_mem_rden    <= w_mem_rden_nxt;
         r_mem_wr_data <= w_mem_wr_data_nxt;
      end
   end

   // Strobes and PREADY default low so each is a single-cycle pulse; address/data/PRDATA hold.
   always_comb begin
      w_state_nxt       = r_state;
      w_is_wr_nxt       = r_is_wr;
      w_prdata_nxt      = r_prdata;
      w_pready_nxt      = 1'b0;
      w_pslverr_nxt     = 1'b0;
      w_mem_addr_nxt    = r_mem_addr;
      w_mem_ce_nxt      = 1'b0;
      w_mem_wren_nxt    = 1'b0;
      w_mem_rden_nxt    = 1'b0;
      w_mem_wr_data_nxt = r_mem_wr_data;

      case (r_state)
         ST_IDLE: begin
            if (w_setup) begin
               if (w_in_range) begin
                  w_mem_addr_nxt    = apb.PADDR[ADDR_WIDTH-1:0];
                  w_mem_wr_data_nxt = apb.PWDATA;
                  w_is_wr_nxt       = apb.PWRITE;
                  w_mem_ce_nxt      = 1'b1;
                  w_mem_wren_nxt    = apb.PWRITE;
                  w_mem_rden_nxt    = !apb.PWRITE;
                  w_state_nxt       = ST_CMD;
               end else begin
                  w_pready_nxt  = 1'b1;
                  w_pslverr_nxt = 1'b1;
                  w_prdata_nxt  = '0;
                  w_state_nxt   = ST_RESP;
               end
            end
         end
         ST_CMD: begin
            if (r_is_wr) begin
               w_pready_nxt = 1'b1;
               w_state_nxt  = ST_RESP;
            end else begin
               w_state_nxt  = ST_WAIT;
            end
         end
         ST_WAIT: begin
            w_prdata_nxt = mem_rd_data;
            w_pready_nxt = 1'b1;
            w_state_nxt  = ST_RESP;
         end
         ST_RESP: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign apb.PRDATA  = r_prdata;
   assign apb.PREADY  = r_pready;
   assign apb.PSLVERR = r_pslverr;

   assign mem_addr    = r_mem_addr;
   assign mem_ce      = r_mem_ce;
   assign mem_wren    = r_mem_wren;
   assign mem_rden    = r_mem_rden;
   assign mem_wr_data = r_mem_wr_data;

endmodule
